// File: rtl/bundle_sequencer.sv
// Hypervector bundle sequencer: per dimension, read the feature bits, capture the bundler's
// thresholded bit, and stream the hypervector as 32-bit words. BUNDLE_SEQ_ONES_COUNT_EN adds hv_ones_count.
module bundle_sequencer #(
   parameter int unsigned FEATURE_COUNT = 617,
   parameter int unsigned HV_DIM        = 1024
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         start,
   output logic                         feat_rd_en,
   output logic [$clog2(HV_DIM)-1:0]    feat_rd_addr,
   input  logic [FEATURE_COUNT-1:0]     feat_rd_data,
   output logic                         bundling_features,
   output logic [FEATURE_COUNT-1:0]     bits_to_bundle,
   input  logic                         thresholded_bit,
   output logic                         hv_out_valid,
   input  logic                         hv_out_ready,
   output logic [31:0]                  hv_out_word,
   output logic                         busy,
   output logic                         done
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
   ,
   output logic [$clog2(HV_DIM+1)-1:0]  hv_ones_count
`endif
);

   localparam int unsigned DW = $clog2(HV_DIM);
   localparam logic [DW-1:0] LastDim = DW'(HV_DIM - 1);

   typedef enum logic [2:0] {StIdle, StRd, StBnd, StOut, StDone} state_e;

   state_e          state_q;
   logic [DW-1:0]   d_q;
   logic [31:0]     word_q;

   assign feat_rd_addr   = d_q;
   assign hv_out_word    = word_q;
   // Read data arrives in the BND cycle, so it is gated straight through rather than registered.
   assign bits_to_bundle = bundling_features ? feat_rd_data : '0;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q           <= StIdle;
         d_q               <= '0;
         word_q            <= '0;
         feat_rd_en        <= 1'b0;
         bundling_features <= 1'b0;
         hv_out_valid      <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
         hv_ones_count     <= '0;
`endif
      end else begin
         feat_rd_en        <= 1'b0;
         bundling_features <= 1'b0;
         done              <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StRd;
                  d_q        <= '0;
                  feat_rd_en <= 1'b1;
                  busy       <= 1'b1;
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
                  hv_ones_count <= '0;
`endif
               end
            end
            StRd: begin
               state_q           <= StBnd;
               bundling_features <= 1'b1;
            end
            StBnd: begin
               word_q[d_q[4:0]] <= thresholded_bit;
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
               if (thresholded_bit) hv_ones_count <= hv_ones_count + 1'b1;
`endif
               if (d_q[4:0] != 5'd31) begin
                  state_q    <= StRd;
                  d_q        <= d_q + DW'(1);
                  feat_rd_en <= 1'b1;
               end else begin
                  state_q      <= StOut;
                  hv_out_valid <= 1'b1;
               end
            end
            StOut: begin
               if (hv_out_ready) begin
                  word_q       <= '0;
                  hv_out_valid <= 1'b0;
                  if (d_q == LastDim) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q    <= StRd;
                     d_q        <= d_q + DW'(1);
                     feat_rd_en <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Scoreboard bench for bundle_sequencer: expected words queued at start, popped on handshake.
// Define BUNDLE_SEQ_ONES_COUNT_EN for both files to cover the ones counter.
module tb_bundle_sequencer;

   localparam int unsigned FC  = 617;
   localparam int unsigned DIM = 1024;
   localparam int unsigned AW  = $clog2(DIM);
   localparam int unsigned NW  = DIM / 32;

   logic           clk = 1'b0;
   logic           nrst = 1'b0;
   logic           start = 1'b0;
   logic           hv_out_ready = 1'b1;
   logic           feat_rd_en;
   logic [AW-1:0]  feat_rd_addr;
   logic [FC-1:0]  feat_rd_data = '1;
   logic           bundling_features;
   logic [FC-1:0]  bits_to_bundle;
   logic           thresholded_bit;
   logic           hv_out_valid;
   logic [31:0]    hv_out_word;
   logic           busy;
   logic           done;
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
   logic [$clog2(DIM+1)-1:0] hv_ones_count;
`endif

   bundle_sequencer #(.FEATURE_COUNT(FC), .HV_DIM(DIM)) dut (
      .clk(clk), .nrst(nrst), .start(start),
      .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
      .bundling_features(bundling_features), .bits_to_bundle(bits_to_bundle),
      .thresholded_bit(thresholded_bit),
      .hv_out_valid(hv_out_valid), .hv_out_ready(hv_out_ready), .hv_out_word(hv_out_word),
      .busy(busy), .done(done)
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
      , .hv_ones_count(hv_ones_count)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          cycle = 0;
   int          mode = 0;
   bit          mon_en = 1'b0;
   int          mon_next = 0;
   logic        prev_rd_en = 1'b0;
   logic [31:0] exp_q[$];

   function automatic logic pat(input int m, input int dim);
      if (m == 0) return 1'b1;
      if (m == 1) return (dim % 2) == 0;
      return (((dim ^ (dim >> 3) ^ (dim >> 6)) & 1) != 0);
   endfunction

   // Memory with one-cycle read latency; junk (all ones) whenever not read.
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (feat_rd_en) feat_rd_data <= pat(mode, int'(feat_rd_addr)) ? '1 : '0;
      else            feat_rd_data <= '1;
   end

   // Majority bundler.
   assign thresholded_bit = ($countones(bits_to_bundle) > FC / 2);

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (bundling_features !== prev_rd_en) begin
            failures++;
            $display("FAIL bundle_after_read: bundling_features=%b, required %b", bundling_features,
                     prev_rd_en);
         end
         if (!bundling_features) begin
            checks++;
            if (bits_to_bundle !== '0) begin
               failures++;
               $display("FAIL bits_idle_zero: bits_to_bundle=%h, required 0", bits_to_bundle);
            end
         end
         if (feat_rd_en) begin
            checks++;
            if (feat_rd_addr !== AW'(mon_next)) begin
               failures++;
               $display("FAIL rd_addr_seq: addr=%0d, required %0d", feat_rd_addr, mon_next);
            end
            mon_next++;
         end
         prev_rd_en = feat_rd_en;
      end
   end

   task automatic run_stream(input string name, input int m, input int stall_k, input int stall_len,
                             input int restart_at);
      int          k, wc, rel, t0, ones, exp_cyc;
      logic [31:0] w, held;
      bit          got_done;
      mode = m;
      exp_q.delete();
      ones = 0;
      for (int kk = 0; kk < NW; kk++) begin
         for (int i = 0; i < 32; i++) begin
            w[i] = pat(m, 32 * kk + i);
            if (w[i]) ones++;
         end
         exp_q.push_back(w);
      end
      @(negedge clk);
      start = 1'b1;
      hv_out_ready = 1'b1;
      t0 = cycle;
      mon_next = 0;
      prev_rd_en = 1'b0;
      mon_en = 1'b1;
      k = 0; wc = 0; got_done = 1'b0; held = '0;
      for (int n = 0; n < 2400 && !got_done; n++) begin
         @(negedge clk);
         rel = cycle - t0;
         start = (rel == restart_at);
         if (hv_out_valid) begin
            checks++;
            if (wc == 0) begin
               exp_cyc = 65 * (k + 1) + ((k > stall_k) ? stall_len : 0);
               held = hv_out_word;
               if (rel != exp_cyc) begin
                  failures++;
                  $display("FAIL %s word%0d_timing: cycle %0d, required %0d", name, k, rel, exp_cyc);
               end
            end else if (hv_out_word !== held || feat_rd_en !== 1'b0) begin
               failures++;
               $display("FAIL %s stall_hold: word=%h rd_en=%b, required %h and 0", name, hv_out_word,
                        feat_rd_en, held);
            end
            if (k == stall_k && wc < stall_len) begin
               hv_out_ready = 1'b0;
               wc++;
            end else begin
               hv_out_ready = 1'b1;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL %s extra_word: got %h, required none", name, hv_out_word);
               end else begin
                  w = exp_q.pop_front();
                  if (hv_out_word !== w) begin
                     failures++;
                     $display("FAIL %s word%0d: got %h, required %h", name, k, hv_out_word, w);
                  end
               end
               k++;
               wc = 0;
            end
         end else if (done) begin
            got_done = 1'b1;
            checks += 3;
            if (rel != 2081 + stall_len) begin
               failures++;
               $display("FAIL %s done_timing: cycle %0d, required %0d", name, rel, 2081 + stall_len);
            end
            if (exp_q.size() != 0) begin
               failures++;
               $display("FAIL %s words_left: %0d, required 0", name, exp_q.size());
            end
            if (mon_next != DIM) begin
               failures++;
               $display("FAIL %s read_count: %0d, required %0d", name, mon_next, DIM);
            end
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
            checks++;
            if (int'(hv_ones_count) != ones) begin
               failures++;
               $display("FAIL %s ones_count: %0d, required %0d", name, hv_ones_count, ones);
            end
`endif
         end
      end
      if (!got_done) begin
         checks++;
         failures++;
         $display("FAIL %s done_timeout: no done seen, required one", name);
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s post_done: busy=%b done=%b, required 0 0", name, busy, done);
      end
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
      repeat (3) @(negedge clk);
      checks++;
      if (int'(hv_ones_count) != ones) begin
         failures++;
         $display("FAIL %s ones_hold: %0d, required %0d", name, hv_ones_count, ones);
      end
`endif
      mon_en = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, hv_out_valid, feat_rd_en, bundling_features} !== 5'b0 ||
          feat_rd_addr !== '0 || hv_out_word !== '0 || bits_to_bundle !== '0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b valid=%b rd=%b bnd=%b addr=%0d word=%h, required 0",
                  busy, done, hv_out_valid, feat_rd_en, bundling_features, feat_rd_addr, hv_out_word);
      end
      start = 1'b0;
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_start_ignored: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_all_ones();        run_stream("all_ones", 0, -1, 0, -1); endtask
   task automatic test_even_dims();       run_stream("even_dims", 1, -1, 0, -1); endtask
   task automatic test_stall();           run_stream("stall", 2, 3, 10, -1); endtask
   task automatic test_restart_ignored(); run_stream("restart", 2, -1, 0, 500); endtask

   task automatic test_mid_reset();
      int  t0;
      bit  seen;
      mode = 2;
      hv_out_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      t0 = cycle;
      @(negedge clk);
      start = 1'b0;
      while (cycle - t0 < 700) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      checks++;
      if ({busy, done, hv_out_valid, feat_rd_en, bundling_features} !== 5'b0 || hv_out_word !== '0) begin
         failures++;
         $display("FAIL midrun_reset: busy=%b done=%b valid=%b rd=%b word=%h, required 0",
                  busy, done, hv_out_valid, feat_rd_en, hv_out_word);
      end
      seen = 1'b0;
      repeat (150) begin
         @(negedge clk);
         if (done || hv_out_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL midrun_quiet: activity after reset, required none");
      end
      // Reset while a word is held in OUT by a stalled consumer.
      hv_out_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = hv_out_valid;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL stall_reset_valid: valid never rose, required 1");
      end
      repeat (3) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      hv_out_ready = 1'b1;
      checks++;
      if (hv_out_valid !== 1'b0 || busy !== 1'b0 || hv_out_word !== '0) begin
         failures++;
         $display("FAIL stall_reset: valid=%b busy=%b word=%h, required 0 0 0", hv_out_valid, busy,
                  hv_out_word);
      end
`ifdef BUNDLE_SEQ_ONES_COUNT_EN
      checks++;
      if (hv_ones_count !== '0) begin
         failures++;
         $display("FAIL reset_ones_count: %0d, required 0", hv_ones_count);
      end
`endif
      run_stream("after_reset", 2, -1, 0, -1);
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_even_dims();
      test_stall();
      test_restart_ignored();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bundle_sequencer.md
BUNDLE_SEQUENCER -- requirements
Module: bundle_sequencer

Interface
REQ-001 The module SHALL have parameter FEATURE_COUNT, default 617, giving the number of bound feature bits per hypervector dimension.
REQ-002 The module SHALL have parameter HV_DIM, default 1024, giving the hypervector dimensions; it must be a multiple of 32.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock.
REQ-004 The module SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port start  input  1  one-cycle request to encode one hypervector.
REQ-006 The module SHALL have ports feat_rd_en  output  1 and feat_rd_addr  output  $clog2(HV_DIM)  read strobe and dimension index for the feature-bit memory.
REQ-007 The module SHALL have port feat_rd_data  input  FEATURE_COUNT  memory read data, valid exactly one cycle after feat_rd_en.
REQ-008 The module SHALL have ports bundling_features  output  1 and bits_to_bundle  output  FEATURE_COUNT  drive to the bundler.
REQ-009 The module SHALL have port thresholded_bit  input  1  combinational bundler result.
REQ-010 The module SHALL have ports hv_out_valid  output  1, hv_out_ready  input  1 and hv_out_word  output  32  packed result stream.
REQ-011 The module SHALL have ports busy  output  1  (high in any state other than IDLE) and done  output  1  (one-cycle completion pulse).

Function
REQ-012 The FSM SHALL have the states IDLE, RD, BND, OUT and DONE.
REQ-013 IDLE with start=1 SHALL go to RD with the dimension counter d=0; start in any other state SHALL be ignored.
REQ-014 RD SHALL assert feat_rd_en=1 with feat_rd_addr=d for one cycle, then go to BND.
REQ-015 BND SHALL assert bundling_features=1 and drive bits_to_bundle=feat_rd_data, and SHALL write thresholded_bit into word buffer bit d[4:0] at the clock edge.
REQ-016 BND with d[4:0]!=31 SHALL increment d and go to RD; with d[4:0]=31 it SHALL go to OUT.
REQ-017 Outside BND, bundling_features SHALL be 0 and bits_to_bundle SHALL be all-zero; outside RD, feat_rd_en SHALL be 0.
REQ-018 OUT SHALL hold hv_out_valid=1 and a stable hv_out_word (bit i = dimension 32*k+i of word k) until hv_out_ready=1.
REQ-019 On the OUT handshake, the word buffer SHALL clear and the FSM SHALL go to DONE if d=HV_DIM-1, otherwise increment d and go to RD.
REQ-020 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-021 Timing: each dimension SHALL take 2 cycles, and each word 65 cycles plus any ready stall; with ready held high and start sampled at cycle 0, word k SHALL be valid at cycle 65(k+1), and done at cycle 2081 for HV_DIM=1024.
REQ-022 The counter d SHALL never wrap during a run; it SHALL reset to 0 on each accepted start.

Reset
REQ-023 While nrst=0 at a clock edge, the FSM SHALL go to IDLE, and d, the word buffer and all outputs SHALL clear to 0, including mid-run and mid-OUT stall.
REQ-024 A partially emitted hypervector SHALL be discarded on reset, and no done pulse SHALL follow.

Configuration
REQ-025 With BUNDLE_SEQ_ONES_COUNT_EN defined, the module SHALL add port hv_ones_count  output  $clog2(HV_DIM+1), reset to 0 on an accepted start, incremented in each BND cycle where thresholded_bit=1, and held stable from DONE until the next start.
REQ-026 Without BUNDLE_SEQ_ONES_COUNT_EN, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-027 Bench: feat_rd_data all-ones, bundler threshold met, ready high, start -> 32 words of 0xFFFFFFFF at cycles 65,130,...,2080; done at 2081.
REQ-028 Bench: memory returns ones only for even dimensions -> every word 0x55555555; with macro, hv_ones_count=512.
REQ-029 Bench: hv_out_ready held low 10 cycles on word 3 -> hv_out_word stable; no RD issued; done delayed to cycle 2091.
REQ-030 Bench: start pulsed again at cycle 500 -> ignored; word sequence and done timing unchanged.
REQ-031 Bench: nrst=0 at cycle 700 for one cycle -> next cycle IDLE with busy=0, valid=0, no done; a new start restarts at d=0.
REQ-032 Bench: check every cycle -> feat_rd_addr sequence 0..1023 each exactly once; bundling_features high only the cycle after feat_rd_en.
